branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Resolution-side companion of the branch predictor.
- Captures each predicted branch at fetch and holds it in an in-order queue.
- At execute, compares each prediction with the actual outcome.
- Drives the predictor's check/update interface, issues fetch redirects on mispredicts, then runs a fixed-length recovery window in which wrong-path fetches are discarded.

Parameters:
- PC_WIDTH, 32, width of PCs and targets.
- DEPTH, 4, in-flight branch queue entries; power of 2, ≥2.
- RECOVER_CYCLES, 2, cycles after a redirect during which pushes are ignored; ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- push_valid  input  1  IF has a conditional branch this cycle
- push_pc  input  PC_WIDTH  PC of that branch
- push_pred_taken  input  1  predictor output for that branch
- push_stall  output  1  queue full; IF must hold
- res_valid  input  1  EX resolves the oldest queued branch this cycle
- res_taken  input  1  actual direction
- res_target  input  PC_WIDTH  taken target
- check_valid  output  1  to predictor is_br_check
- check_pc  output  PC_WIDTH  to predictor pc_check
- check_taken  output  1  to predictor br_taken_check
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  PC_WIDTH  redirect target
- recovering  output  1  high while in RECOVER
- underflow_err  output  1  sticky: res_valid seen with queue empty

Behaviour:
- Reset: queue empty, FSM to RUN. All outputs 0 except push_stall=0.
- Queue:
  - Circular FIFO of {pc, pred_taken}.
  - Pointers are log2(DEPTH)+1 bits with a wrap bit. Full when indices are equal and wrap bits differ.
  - push_stall = full, combinational.
- Push is accepted when push_valid && !full && state==RUN.
  - Pushes in RECOVER are silently dropped (wrong path).
  - A push while full is ignored; IF holds on push_stall.
- Pop occurs when res_valid && !empty.
  - The head entry is compared with res_taken. mispredict = head.pred_taken != res_taken.
  - res_valid while empty sets underflow_err (cleared only by reset). No other effect.
- Simultaneous push and pop in RUN with no mispredict: both take effect.
  - Allowed even when full, because the pop frees the slot.
  - push_stall remains the combinational full flag regardless.
- Check outputs, 1-cycle registered latency after pop:
  - check_valid=1, check_pc=head.pc, check_taken=res_taken, for every pop.
  - Otherwise check_valid=0; check_pc and check_taken hold their last values.
- Mispredict on pop:
  - Next cycle: redirect_valid=1 for exactly 1 cycle.
  - redirect_pc = res_target if res_taken, else head.pc + 4 (modulo 2^PC_WIDTH).
  - The whole queue is flushed (pointers equal, count 0), including any push in the same cycle.
  - FSM goes to RECOVER with a countdown loaded to RECOVER_CYCLES.
- FSM:
  - RUN → RECOVER on a mispredict pop.
  - RECOVER: recovering=1. Pushes are dropped. res_valid is ignored (no check, no underflow). The counter decrements each cycle. At 1 → RUN.
  - Only RUN → RECOVER and RECOVER → RUN transitions exist; the counter ensures recovering stays high exactly RECOVER_CYCLES cycles.
- Reset asserted mid-operation: everything returns to reset values on the next edge. Pending check and redirect pulses are discarded.

Optional Feature:
- Macro: BR_RESOLVER_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] (pops) and stat_mispredicts[31:0].
  - Both are free-running wrapping counters, cleared on reset, incremented in the cycle of the pop.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (bp_pkg): FSM state encoding (ST_RUN, ST_RECOVER), queue entry struct {pc, pred_taken}, constant INSTR_BYTES=4.
- One sub-module: br_queue (FIFO with push/pop/flush, full/empty, head read).
- The FSM, compare logic and check/redirect registers stay in branch_resolver.

Test Plan:
- Correct prediction: push pc=0x100, pred=1; then res_valid, taken=1, target=0x200.
  - Next cycle: check_valid=1, check_pc=0x100, check_taken=1, redirect_valid=0.
- Not-taken mispredict: push 0x104 pred=1; resolve taken=0.
  - Next cycle: redirect_valid=1, redirect_pc=0x108.
  - recovering high for 2 cycles; pushes in those cycles are dropped; queue empty afterwards.
- Taken mispredict with concurrent push:
  - Queue holds 0x10, 0x14. Resolve 0x10 pred=0 taken=1 target=0x40 while pushing 0x18.
  - Redirect to 0x40; queue empty; 0x18 is lost.
- Full boundary (DEPTH=4):
  - Push 4 branches: push_stall=1 and a 5th push is ignored.
  - Simultaneous correct pop and push: both occur, count stays 4, order preserved.
- Underflow: res_valid with empty queue sets underflow_err=1, check_valid stays 0; a later reset clears it.
- Stats (macro on): 3 pops with 1 mispredict gives stat_branches=3, stat_mispredicts=1; reset mid-RECOVER zeroes both and returns the FSM to RUN.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolver: FSM encoding, queue entry layout
// and the instruction size used to form fall-through PCs.
package bp_pkg;

    localparam int BP_PC_WIDTH = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    // Entry layout at the default PC width; the queue stores {pc, pred_taken} in this order.
    typedef struct packed {
        logic [BP_PC_WIDTH-1:0] pc;
        logic                   pred_taken;
    } br_entry_t;

endpackage

// File: rtl/br_queue.sv
// In-order circular FIFO of predicted branches with a wrap-bit pointer scheme,
// combinational head read and a flush that empties the queue in one cycle.
module br_queue
    import bp_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DEPTH];

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage, cleared on reset so the head never reads unknown data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued branch predictions against execute outcomes, feeds the
// predictor check port, redirects fetch on mispredicts and runs a recovery window.
// Optional statistics counters are enabled with BR_RESOLVER_STATS_EN.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_valid,
    input  logic [PC_WIDTH-1:0] push_pc,
    input  logic                push_pred_taken,
    output logic                push_stall,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic [PC_WIDTH-1:0] res_target,
    output logic                check_valid,
    output logic [PC_WIDTH-1:0] check_pc,
    output logic                check_taken,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                recovering,
    output logic                underflow_err
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int CW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RECOVER_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]          state_r;
    logic [CW-1:0]       cnt_r;
    logic [PC_WIDTH:0]   head_s;
    logic [PC_WIDTH-1:0] head_pc_s;
    logic                head_pred_s;
    logic                full_s;
    logic                empty_s;
    logic                pop_s;
    logic                push_s;
    logic                mispredict_s;
    logic                underflow_s;

    assign head_pc_s   = head_s[PC_WIDTH:1];
    assign head_pred_s = head_s[0];
    assign push_stall  = full_s;
    assign recovering  = (state_r == ST_RECOVER);

    // Handshake decode; nothing moves while recovering, and a mispredict suppresses the push.
    always_comb begin
        pop_s        = 1'b0;
        push_s       = 1'b0;
        mispredict_s = 1'b0;
        underflow_s  = 1'b0;
        if (state_r == ST_RUN) begin
            pop_s        = res_valid && !empty_s;
            underflow_s  = res_valid && empty_s;
            mispredict_s = pop_s && (head_pred_s != res_taken);
            push_s       = push_valid && (!full_s || pop_s) && !mispredict_s;
        end else begin
            pop_s        = 1'b0;
            push_s       = 1'b0;
        end
    end

    br_queue #(
        .W     (PC_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({push_pc, push_pred_taken}),
        .pop       (pop_s),
        .flush     (mispredict_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Predictor check port and fetch redirect; pc/taken fields hold between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            check_valid    <= 1'b0;
            check_pc       <= {PC_WIDTH{1'b0}};
            check_taken    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= {PC_WIDTH{1'b0}};
            underflow_err  <= 1'b0;
        end else begin
            check_valid    <= pop_s;
            redirect_valid <= mispredict_s;
            if (pop_s) begin
                check_pc    <= head_pc_s;
                check_taken <= res_taken;
            end
            if (mispredict_s) begin
                redirect_pc <= res_taken ? res_target : (head_pc_s + PC_WIDTH'(INSTR_BYTES));
            end
            if (underflow_s) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Recovery FSM: the countdown keeps recovering high for exactly RECOVER_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mispredict_s) begin
                        state_r <= ST_RECOVER;
                        cnt_r   <= CNT_LOAD;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

`ifdef BR_RESOLVER_STATS_EN
    // Free-running wrapping counters of resolved branches and mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (pop_s) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict_s) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed table-driven bench for branch_resolver plus hand sequences for reset
// and (with BR_RESOLVER_STATS_EN) the statistics counters.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic        push_stall;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        check_valid;
    logic [31:0] check_pc;
    logic        check_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        recovering;
    logic        underflow_err;
`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        pp;
        logic        rv;
        logic        rt;
        logic [31:0] rtgt;
        logic        cv;
        logic [31:0] cpc;
        logic        ct;
        logic        rdv;
        logic [31:0] rdpc;
        logic        rec;
        logic        st;
        logic        uf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    branch_resolver #(.PC_WIDTH(32), .DEPTH(4), .RECOVER_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .push_valid      (push_valid),
        .push_pc         (push_pc),
        .push_pred_taken (push_pred_taken),
        .push_stall      (push_stall),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .check_valid     (check_valid),
        .check_pc        (check_pc),
        .check_taken     (check_taken),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .recovering      (recovering),
        .underflow_err   (underflow_err)
`ifdef BR_RESOLVER_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [31:0] ppc, input logic pp,
                       input logic rv, input logic rt, input logic [31:0] rtgt,
                       input logic cv, input logic [31:0] cpc, input logic ct,
                       input logic rdv, input logic [31:0] rdpc, input logic rec,
                       input logic st, input logic uf);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.pp = pp; v.rv = rv; v.rt = rt; v.rtgt = rtgt;
        v.cv = cv; v.cpc = cpc; v.ct = ct; v.rdv = rdv; v.rdpc = rdpc;
        v.rec = rec; v.st = st; v.uf = uf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic pp,
                         input logic rv, input logic rt, input logic [31:0] rtgt);
        push_valid = pv; push_pc = ppc; push_pred_taken = pp;
        res_valid = rv; res_taken = rt; res_target = rtgt;
    endtask

    task automatic check_outs(input int idx, input logic cv, input logic [31:0] cpc, input logic ct,
                              input logic rdv, input logic [31:0] rdpc, input logic rec,
                              input logic st, input logic uf);
        chk("check_valid", idx, {31'd0, check_valid}, {31'd0, cv});
        chk("check_pc", idx, check_pc, cpc);
        chk("check_taken", idx, {31'd0, check_taken}, {31'd0, ct});
        chk("redirect_valid", idx, {31'd0, redirect_valid}, {31'd0, rdv});
        chk("redirect_pc", idx, redirect_pc, rdpc);
        chk("recovering", idx, {31'd0, recovering}, {31'd0, rec});
        chk("push_stall", idx, {31'd0, push_stall}, {31'd0, st});
        chk("underflow_err", idx, {31'd0, underflow_err}, {31'd0, uf});
    endtask

    initial begin
        //   pv  ppc        pp  rv  rt  rtgt        cv  cpc        ct  rdv rdpc       rec st  uf
        // correct prediction
        add(1, 32'h100, 1, 0, 0, 32'h0,   0, 32'h0,    0, 0, 32'h0,   0, 0, 0);
        add(0, 32'h0,   0, 1, 1, 32'h200, 1, 32'h100,  1, 0, 32'h0,   0, 0, 0);
        // not-taken mispredict, recovery drops pushes and ignores res_valid
        add(1, 32'h104, 1, 0, 0, 32'h0,   0, 32'h100,  1, 0, 32'h0,   0, 0, 0);
        add(0, 32'h0,   0, 1, 0, 32'h0,   1, 32'h104,  0, 1, 32'h108, 1, 0, 0);
        add(1, 32'h300, 0, 1, 1, 32'h0,   0, 32'h104,  0, 0, 32'h108, 1, 0, 0);
        add(1, 32'h304, 0, 0, 0, 32'h0,   0, 32'h104,  0, 0, 32'h108, 0, 0, 0);
        // queue is empty after recovery: resolve underflows
        add(0, 32'h0,   0, 1, 1, 32'h0,   0, 32'h104,  0, 0, 32'h108, 0, 0, 1);
        // taken mispredict with concurrent push
        add(1, 32'h10,  0, 0, 0, 32'h0,   0, 32'h104,  0, 0, 32'h108, 0, 0, 1);
        add(1, 32'h14,  0, 0, 0, 32'h0,   0, 32'h104,  0, 0, 32'h108, 0, 0, 1);
        add(1, 32'h18,  1, 1, 1, 32'h40,  1, 32'h10,   1, 1, 32'h40,  1, 0, 1);
        add(0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h10,   1, 0, 32'h40,  1, 0, 1);
        add(0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h10,   1, 0, 32'h40,  0, 0, 1);
        add(1, 32'h20,  0, 0, 0, 32'h0,   0, 32'h10,   1, 0, 32'h40,  0, 0, 1);
        add(0, 32'h0,   0, 1, 0, 32'h0,   1, 32'h20,   0, 0, 32'h40,  0, 0, 1);
        // full boundary
        add(1, 32'h1000, 1, 0, 0, 32'h0,  0, 32'h20,   0, 0, 32'h40,  0, 0, 1);
        add(1, 32'h1004, 0, 0, 0, 32'h0,  0, 32'h20,   0, 0, 32'h40,  0, 0, 1);
        add(1, 32'h1008, 1, 0, 0, 32'h0,  0, 32'h20,   0, 0, 32'h40,  0, 0, 1);
        add(1, 32'h100C, 0, 0, 0, 32'h0,  0, 32'h20,   0, 0, 32'h40,  0, 1, 1);
        add(1, 32'h1010, 1, 0, 0, 32'h0,  0, 32'h20,   0, 0, 32'h40,  0, 1, 1);
        add(1, 32'h1014, 0, 1, 1, 32'h0,  1, 32'h1000, 1, 0, 32'h40,  0, 1, 1);
        add(0, 32'h0,    0, 1, 0, 32'h0,  1, 32'h1004, 0, 0, 32'h40,  0, 0, 1);
        add(0, 32'h0,    0, 1, 1, 32'h0,  1, 32'h1008, 1, 0, 32'h40,  0, 0, 1);
        add(0, 32'h0,    0, 1, 0, 32'h0,  1, 32'h100C, 0, 0, 32'h40,  0, 0, 1);
        add(0, 32'h0,    0, 1, 0, 32'h0,  1, 32'h1014, 0, 0, 32'h40,  0, 0, 1);
        add(0, 32'h0,    0, 1, 1, 32'h0,  0, 32'h1014, 0, 0, 32'h40,  0, 0, 1);

        reset = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_outs(-1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pv, vecs[i].ppc, vecs[i].pp, vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
            @(posedge clk);
            #1;
            check_outs(i, vecs[i].cv, vecs[i].cpc, vecs[i].ct, vecs[i].rdv,
                       vecs[i].rdpc, vecs[i].rec, vecs[i].st, vecs[i].uf);
        end

        // Reset coinciding with a mispredict pop discards the pulses and clears underflow_err
        drive(1, 32'h500, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 32'h0, 0, 1, 1, 32'h600);
        reset = 1'b1;
        @(posedge clk); #1;
        check_outs(100, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
        reset = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check_outs(101, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);

`ifdef BR_RESOLVER_STATS_EN
        // Three pops, one mispredict, then reset mid-recovery
        drive(1, 32'h700, 1, 0, 0, 32'h0); @(posedge clk); #1;
        drive(1, 32'h704, 1, 0, 0, 32'h0); @(posedge clk); #1;
        drive(1, 32'h708, 1, 0, 0, 32'h0); @(posedge clk); #1;
        drive(0, 32'h0, 0, 1, 1, 32'h0);   @(posedge clk); #1;
        drive(0, 32'h0, 0, 1, 1, 32'h0);   @(posedge clk); #1;
        drive(0, 32'h0, 0, 1, 0, 32'h0);   @(posedge clk); #1;
        chk("stat_branches", 200, stat_branches, 32'd3);
        chk("stat_mispredicts", 200, stat_mispredicts, 32'd1);
        chk("recovering", 200, {31'd0, recovering}, 32'd1);
        chk("redirect_pc", 200, redirect_pc, 32'h70C);
        drive(0, 32'h0, 0, 0, 0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("stat_branches", 201, stat_branches, 32'd0);
        chk("stat_mispredicts", 201, stat_mispredicts, 32'd0);
        chk("recovering", 201, {31'd0, recovering}, 32'd0);
        chk("redirect_valid", 201, {31'd0, redirect_valid}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
